sar_cdac_model: RTL

SAR_CDAC_MODEL -- requirements
Module: sar_cdac_model

---
 rtl/sar_cdac_model.sv | 89 ++++++++
 1 files changed

// File: rtl/sar_cdac_model.sv
// sar_cdac_model: sample-and-hold plus capacitive-DAC comparator model driven by an external SAR controller.
module sar_cdac_model #(
  parameter int WIDTH      = 4,
  parameter int TRACK_CYC  = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] vin_code,
  input  logic             start,
  input  logic [WIDTH-1:0] trial,
  input  logic             trial_valid,
  output logic [WIDTH-1:0] held,
  output logic             cmp,
  output logic             cmp_valid,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, TRACK, HOLD, SETTLE} state_t;
  state_t           r_state, w_next;
  logic [7:0]       r_track_cnt, r_settle_cnt;
  logic [CW-1:0]    r_cmp_cnt;
  logic [WIDTH-1:0] r_dac, r_held;
  logic             r_cmp, r_cmp_valid, r_busy, r_done;
  logic             w_track_end, w_settle_end, w_last;
  assign w_track_end  = r_track_cnt == 8'(TRACK_CYC - 1);
  assign w_settle_end = r_settle_cnt == 8'(SETTLE_CYC);
  assign w_last       = r_cmp_cnt == CW'(WIDTH - 1);
  always_ff @(posedge clock or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = start ? TRACK : IDLE;
      TRACK:   w_next = w_track_end ? HOLD : TRACK;
      HOLD:    w_next = trial_valid ? SETTLE : HOLD;
      SETTLE:  w_next = !w_settle_end ? SETTLE : (w_last ? IDLE : HOLD);
      default: w_next = IDLE;
    endcase
  end
  // busy is registered from the next state so it tracks the FSM with no output lag
  always_ff @(posedge clock or posedge rst)
    if (rst) begin
      r_track_cnt  <= '0;
      r_settle_cnt <= '0;
      r_cmp_cnt    <= '0;
      r_dac        <= '0;
      r_held       <= '0;
      r_cmp        <= 1'b0;
      r_cmp_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_cmp_valid <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= w_next != IDLE;
      case (r_state)
        IDLE: if (start) begin
          r_track_cnt <= '0;
          r_cmp_cnt   <= '0;
        end
        TRACK: begin
          r_held      <= vin_code;
          r_track_cnt <= r_track_cnt + 8'd1;
        end
        HOLD: if (trial_valid) begin
          r_dac        <= trial;
          r_settle_cnt <= '0;
        end
        SETTLE: begin
          r_settle_cnt <= r_settle_cnt + 8'd1;
          if (w_settle_end) begin
            r_cmp       <= r_held >= r_dac;
            r_cmp_valid <= 1'b1;
            r_cmp_cnt   <= r_cmp_cnt + 1'b1;
            r_done      <= w_last;
          end
        end
        default: ;
      endcase
    end
  assign held      = r_held;
  assign cmp       = r_cmp;
  assign cmp_valid = r_cmp_valid;
  assign busy      = r_busy;
  assign done      = r_done;
endmodule
